// File: rtl/axil_selftest_sequencer_pkg.sv
// Shared types and constants for the AXI4-Lite write/readback self-test sequencer.
package axil_selftest_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_DATA,
      FINISH
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_BRESP   = 2'd1;
   localparam logic [1:0] ERR_RDATA   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/axil_selftest_sequencer_if.sv
// AXI4-Lite bus between the self-test sequencer (master) and the register bank (slave).
interface axil_selftest_sequencer_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0]   AWADDR;
   logic [2:0]              AWPROT;
   logic                    AWVALID;
   logic                    AWREADY;
   logic [DATA_WIDTH-1:0]   WDATA;
   logic [DATA_WIDTH/8-1:0] WSTRB;
   logic                    WVALID;
   logic                    WREADY;
   logic [1:0]              BRESP;
   logic                    BVALID;
   logic                    BREADY;
   logic [ADDR_WIDTH-1:0]   ARADDR;
   logic [2:0]              ARPROT;
   logic                    ARVALID;
   logic                    ARREADY;
   logic [DATA_WIDTH-1:0]   RDATA;
   logic [1:0]              RRESP;
   logic                    RVALID;
   logic                    RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      output ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      input  ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

endinterface

// File: rtl/axil_selftest_sequencer.sv
// AXI4-Lite master: writes BASE_DATA+i to NUM_REGS registers, reads them back and compares,
// reporting pass/fail, the first failing index and its cause. Every handshake is time-bounded.
module axil_selftest_sequencer
   import axil_selftest_pkg::*;
#(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32,   // only 32 is supported
   parameter int unsigned NUM_REGS           = 4,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter logic [C_M_AXI_DATA_WIDTH-1:0] BASE_DATA = 1,
   parameter int unsigned TIMEOUT_CYC        = 1024
) (
   input  logic                       ACLK,
   input  logic                       ARESET,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [7:0]                 err_idx,
   output logic [1:0]                 err_code,
   axil_selftest_sequencer_if.master  M_AXI
);

   localparam logic [7:0]  LAST_IDX = 8'(NUM_REGS - 1);
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

   state_t      state_q, state_d;
   logic [7:0]  idx_q, idx_d;
   logic        aw_ok_q, aw_ok_d;
   logic        w_ok_q, w_ok_d;
   logic        pass_q, pass_d;
   logic [7:0]  err_idx_q, err_idx_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [31:0] tmo_q;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, timed_out;
   logic [C_M_AXI_DATA_WIDTH-1:0] exp_data;

   assign exp_data = BASE_DATA + C_M_AXI_DATA_WIDTH'(idx_q);

   // VALID/READY are decoded from registered state only, so a timeout clears them at once.
   assign M_AXI.AWVALID = (state_q == WR_REQ) && !aw_ok_q;
   assign M_AXI.WVALID  = (state_q == WR_REQ) && !w_ok_q;
   assign M_AXI.BREADY  = (state_q == WR_RESP);
   assign M_AXI.ARVALID = (state_q == RD_REQ);
   assign M_AXI.RREADY  = (state_q == RD_DATA);

   assign M_AXI.AWADDR  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});
   assign M_AXI.ARADDR  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});
   assign M_AXI.AWPROT  = 3'b000;
   assign M_AXI.ARPROT  = 3'b000;
   assign M_AXI.WDATA   = exp_data;
   assign M_AXI.WSTRB   = '1;

   assign aw_hs  = M_AXI.AWVALID && M_AXI.AWREADY;
   assign w_hs   = M_AXI.WVALID  && M_AXI.WREADY;
   assign b_hs   = M_AXI.BVALID  && M_AXI.BREADY;
   assign ar_hs  = M_AXI.ARVALID && M_AXI.ARREADY;
   assign r_hs   = M_AXI.RVALID  && M_AXI.RREADY;
   assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;
   assign timed_out = (tmo_q == TMO_LAST);

   assign busy     = (state_q != IDLE) && (state_q != FINISH);
   assign done     = (state_q == FINISH);
   assign pass     = pass_q;
   assign err_idx  = err_idx_q;
   assign err_code = err_code_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      aw_ok_d    = aw_ok_q;
      w_ok_d     = w_ok_q;
      pass_d     = pass_q;
      err_idx_d  = err_idx_q;
      err_code_d = err_code_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               idx_d      = '0;
               aw_ok_d    = 1'b0;
               w_ok_d     = 1'b0;
               pass_d     = 1'b0;
               err_idx_d  = '0;
               err_code_d = ERR_NONE;
               state_d    = WR_REQ;
            end
         end
         WR_REQ: begin
            if (aw_hs) aw_ok_d = 1'b1;
            if (w_hs)  w_ok_d  = 1'b1;
            if (aw_ok_q && w_ok_q) begin
               aw_ok_d = 1'b0;
               w_ok_d  = 1'b0;
               state_d = WR_RESP;
            end else if (!aw_hs && !w_hs && timed_out) begin
               err_idx_d  = idx_q;
               err_code_d = ERR_TIMEOUT;
               state_d    = FINISH;
            end
         end
         WR_RESP: begin
            if (b_hs) begin
               if (M_AXI.BRESP != RESP_OKAY) begin
                  err_idx_d  = idx_q;
                  err_code_d = ERR_BRESP;
                  state_d    = FINISH;
               end else if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = RD_REQ;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  state_d = WR_REQ;
               end
            end else if (timed_out) begin
               err_idx_d  = idx_q;
               err_code_d = ERR_TIMEOUT;
               state_d    = FINISH;
            end
         end
         RD_REQ: begin
            if (ar_hs) begin
               state_d = RD_DATA;
            end else if (timed_out) begin
               err_idx_d  = idx_q;
               err_code_d = ERR_TIMEOUT;
               state_d    = FINISH;
            end
         end
         RD_DATA: begin
            if (r_hs) begin
               if (M_AXI.RRESP != RESP_OKAY || M_AXI.RDATA != exp_data) begin
                  err_idx_d  = idx_q;
                  err_code_d = ERR_RDATA;
                  state_d    = FINISH;
               end else if (idx_q == LAST_IDX) begin
                  pass_d  = 1'b1;
                  state_d = FINISH;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  state_d = RD_REQ;
               end
            end else if (timed_out) begin
               err_idx_d  = idx_q;
               err_code_d = ERR_TIMEOUT;
               state_d    = FINISH;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         aw_ok_q    <= 1'b0;
         w_ok_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_idx_q  <= '0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         aw_ok_q    <= aw_ok_d;
         w_ok_q     <= w_ok_d;
         pass_q     <= pass_d;
         err_idx_q  <= err_idx_d;
         err_code_q <= err_code_d;
      end
   end

   // Measures how long the current wait has lasted; any progress restarts it.
   always_ff @(posedge ACLK) begin
      if (ARESET || state_q == IDLE || state_d != state_q || any_hs) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_q + 32'd1;
      end
   end

endmodule

// File: tb/tb_axil_selftest_sequencer.sv
// Directed bench: behavioural AXI4-Lite register slave with delay/error knobs around the sequencer.
module tb_axil_selftest_sequencer;

   localparam int unsigned TMO = 32;

   logic       ACLK = 1'b0;
   logic       ARESET = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, pass;
   logic [7:0] err_idx;
   logic [1:0] err_code;

   int checks = 0;
   int errors = 0;

   // slave knobs, written only by the stimulus block
   int aw_dly = 0, w_dly = 0;
   int bresp_err_idx = -1, corrupt_idx = -1;
   bit ar_block = 1'b0;

   always #5 ACLK = ~ACLK;

   axil_selftest_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

   axil_selftest_sequencer #(
      .C_M_AXI_ADDR_WIDTH (32),
      .C_M_AXI_DATA_WIDTH (32),
      .NUM_REGS           (4),
      .BASE_ADDR          (32'h0),
      .BASE_DATA          (32'h1),
      .TIMEOUT_CYC        (TMO)
   ) dut (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .err_idx  (err_idx),
      .err_code (err_code),
      .M_AXI    (axi)
   );

   logic        aw_got, w_got, bvalid, rvalid;
   logic [31:0] aw_addr_l, w_data_l, rdata;
   logic [1:0]  bresp;
   logic [31:0] mem [4];
   int aw_cnt, w_cnt, ar_cnt, aw_wait, w_wait;

   assign axi.AWREADY = axi.AWVALID && !aw_got && (aw_wait >= aw_dly);
   assign axi.WREADY  = axi.WVALID && !w_got && (w_wait >= w_dly);
   assign axi.BVALID  = bvalid;
   assign axi.BRESP   = bresp;
   assign axi.ARREADY = axi.ARVALID && !ar_block && !rvalid;
   assign axi.RVALID  = rvalid;
   assign axi.RDATA   = rdata;
   assign axi.RRESP   = 2'b00;

   always @(posedge ACLK) begin
      if (ARESET) begin
         aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
         aw_addr_l <= '0; w_data_l <= '0; rdata <= '0; bresp <= 2'b00;
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; aw_wait <= 0; w_wait <= 0;
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else begin
         aw_wait <= (axi.AWVALID && !axi.AWREADY) ? aw_wait + 1 : 0;
         w_wait  <= (axi.WVALID && !axi.WREADY) ? w_wait + 1 : 0;
         if (axi.AWVALID && axi.AWREADY) begin
            aw_got <= 1'b1; aw_addr_l <= axi.AWADDR; aw_cnt <= aw_cnt + 1;
         end
         if (axi.WVALID && axi.WREADY) begin
            w_got <= 1'b1; w_data_l <= axi.WDATA; w_cnt <= w_cnt + 1;
         end
         if (aw_got && w_got && !bvalid) begin
            mem[aw_addr_l[3:2]] <= (int'(aw_addr_l[3:2]) == corrupt_idx) ? 32'hDEAD : w_data_l;
            bresp  <= (int'(aw_addr_l[3:2]) == bresp_err_idx) ? 2'b10 : 2'b00;
            bvalid <= 1'b1;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end
         if (bvalid && axi.BREADY) bvalid <= 1'b0;
         if (axi.ARVALID && axi.ARREADY) begin
            rvalid <= 1'b1; rdata <= mem[axi.ARADDR[3:2]]; ar_cnt <= ar_cnt + 1;
         end
         if (rvalid && axi.RREADY) rvalid <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge ACLK); start = 1'b1;
      @(negedge ACLK); start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, output bit seen, output int ar_cyc);
      seen = 1'b0;
      ar_cyc = 0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge ACLK);
         if (axi.ARVALID) ar_cyc++;
         if (done) seen = 1'b1;
      end
   endtask

   bit seen;
   int arc, aw0, w0, ar0;

   initial begin
      repeat (3) @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_pass", 32'(pass), 0);
      check("rst_err", {22'd0, err_idx, err_code}, 0);
      check("rst_valids", {27'd0, axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY}, 0);

      // zero-wait full pass
      pulse_start();
      check("busy_after_start", 32'(busy), 1);
      wait_done(200, seen, arc);
      check("t1_done", 32'(seen), 1);
      check("t1_pass", 32'(pass), 1);
      check("t1_code", 32'(err_code), 0);
      check("t1_busy_at_done", 32'(busy), 0);
      for (int i = 0; i < 4; i++) check("t1_mem", mem[i], 32'(i + 1));
      check("t1_counts", {aw_cnt[7:0], w_cnt[7:0], ar_cnt[7:0]}, 32'h040404);
      @(negedge ACLK);
      check("t1_done_pulse", 32'(done), 0);

      // AW lags W by 3 cycles
      aw_dly = 3; w_dly = 0;
      aw0 = aw_cnt; w0 = w_cnt;
      pulse_start();
      wait_done(300, seen, arc);
      check("t2_done", 32'(seen), 1);
      check("t2_pass", 32'(pass), 1);
      check("t2_aw", 32'(aw_cnt - aw0), 4);
      check("t2_w", 32'(w_cnt - w0), 4);

      // W lags AW by 3 cycles
      aw_dly = 0; w_dly = 3;
      aw0 = aw_cnt; w0 = w_cnt;
      pulse_start();
      wait_done(300, seen, arc);
      check("t3_done", 32'(seen), 1);
      check("t3_pass", 32'(pass), 1);
      check("t3_aw", 32'(aw_cnt - aw0), 4);
      check("t3_w", 32'(w_cnt - w0), 4);
      w_dly = 0;

      // register 2 corrupted
      corrupt_idx = 2;
      ar0 = ar_cnt;
      pulse_start();
      wait_done(300, seen, arc);
      check("t4_done", 32'(seen), 1);
      check("t4_pass", 32'(pass), 0);
      check("t4_code", 32'(err_code), 2);
      check("t4_idx", 32'(err_idx), 2);
      check("t4_reads", 32'(ar_cnt - ar0), 3);
      corrupt_idx = -1;

      // SLVERR on write 1
      bresp_err_idx = 1;
      aw0 = aw_cnt; ar0 = ar_cnt;
      pulse_start();
      wait_done(300, seen, arc);
      check("t5_done", 32'(seen), 1);
      check("t5_pass", 32'(pass), 0);
      check("t5_code", 32'(err_code), 1);
      check("t5_idx", 32'(err_idx), 1);
      check("t5_aw", 32'(aw_cnt - aw0), 2);
      check("t5_ar", 32'(ar_cnt - ar0), 0);
      bresp_err_idx = -1;

      // ARREADY never comes
      ar_block = 1'b1;
      pulse_start();
      wait_done(400, seen, arc);
      check("t6_done", 32'(seen), 1);
      check("t6_code", 32'(err_code), 3);
      check("t6_idx", 32'(err_idx), 0);
      check("t6_ar_cycles", 32'(arc), TMO);
      check("t6_arvalid_low", 32'(axi.ARVALID), 0);
      @(negedge ACLK);
      check("t6_arvalid_after", 32'(axi.ARVALID), 0);
      ar_block = 1'b0;

      // start while busy is ignored
      aw0 = aw_cnt;
      pulse_start();
      repeat (3) @(negedge ACLK);
      start = 1'b1; @(negedge ACLK); start = 1'b0;
      wait_done(300, seen, arc);
      check("t7_done", 32'(seen), 1);
      check("t7_pass", 32'(pass), 1);
      check("t7_aw", 32'(aw_cnt - aw0), 4);
      repeat (3) @(negedge ACLK);
      check("t7_no_rerun", 32'(busy), 0);

      // reset mid read phase, then a clean run
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge ACLK);
         if (axi.ARVALID) seen = 1'b1;
      end
      check("t8_reached_read", 32'(seen), 1);
      ARESET = 1'b1;
      @(negedge ACLK);
      check("t8_rst_busy", 32'(busy), 0);
      check("t8_rst_arvalid", 32'(axi.ARVALID), 0);
      check("t8_rst_pass", 32'(pass), 0);
      @(negedge ACLK);
      ARESET = 1'b0;
      pulse_start();
      wait_done(200, seen, arc);
      check("t8_done", 32'(seen), 1);
      check("t8_pass", 32'(pass), 1);
      check("t8_code", 32'(err_code), 0);
      check("t8_counts", {aw_cnt[7:0], w_cnt[7:0], ar_cnt[7:0]}, 32'h040404);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
